// File: rtl/dot_product_bitserial.sv
// Bit-serial vector x matrix dot product: one bit-plane of the latched vector per cycle,
// shifted by its weight and accumulated per column, with valid/ready request and result handshakes.
module dot_product_bitserial #(
   parameter int RRAM_DOTP_HEIGHT = 512,
   parameter int RRAM_DOTP_WIDTH  = 512,
   parameter int WORD_SIZE        = 16,
   parameter int WORD_SIZE_MATRIX = 8,
   parameter int VEC_BITS         = 8,
   localparam int NB_W            = $clog2(VEC_BITS + 1)
) (
   input  logic                                                     clk_i,
   input  logic                                                     rst_ni,
   input  logic                                                     in_valid_i,
   output logic                                                     in_ready_o,
   input  logic [RRAM_DOTP_HEIGHT*VEC_BITS-1:0]                     vector_i,
   input  logic [NB_W-1:0]                                          nbits_i,
   input  logic                                                     vec_signed_i,
   input  logic                                                     mat_signed_i,
   input  logic [RRAM_DOTP_HEIGHT*RRAM_DOTP_WIDTH*WORD_SIZE_MATRIX-1:0] matrix_i,
   output logic                                                     out_valid_o,
   input  logic                                                     out_ready_i,
   output logic [RRAM_DOTP_WIDTH*WORD_SIZE-1:0]                     result_o,
   output logic                                                     busy_o
);

   localparam int H   = RRAM_DOTP_HEIGHT;
   localparam int W   = RRAM_DOTP_WIDTH;
   localparam int WSM = WORD_SIZE_MATRIX;
   localparam int P_W = (VEC_BITS > 1) ? $clog2(VEC_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [VEC_BITS-1:0]  vec_q [H];
   logic [NB_W-1:0]      nbits_q;
   logic [NB_W-1:0]      nbits_eff;
   logic                 vec_signed_q;
   logic                 mat_signed_q;
   logic [P_W-1:0]       p;
   logic [WORD_SIZE-1:0] acc      [W];
   logic [WORD_SIZE-1:0] acc_next [W];
   logic [WORD_SIZE-1:0] plane    [W];
   logic                 accept;
   logic                 last_plane;

   function automatic logic [WORD_SIZE-1:0] extend(input logic [WSM-1:0] m, input logic sgn);
      return {{(WORD_SIZE-WSM){sgn & m[WSM-1]}}, m};
   endfunction

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready_o is high only in IDLE and out_valid_o only in DONE, so the two never coincide.
   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == DONE);
   assign busy_o      = (state == COMPUTE) || (state == DONE);
   assign accept      = in_valid_i & in_ready_o;

   assign nbits_eff  = ((nbits_i == '0) || (nbits_i > NB_W'(VEC_BITS))) ? NB_W'(VEC_BITS) : nbits_i;
   assign last_plane = (NB_W'(p) == (nbits_q - NB_W'(1)));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid_i)  state_next = COMPUTE;
         COMPUTE: if (last_plane)  state_next = DONE;
         DONE:    if (out_ready_i) state_next = IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   // The top plane of a signed vector carries negative weight, so it is subtracted.
   always_comb begin
      for (int c = 0; c < W; c++) begin
         plane[c] = '0;
         for (int j = 0; j < H; j++) begin
            if (vec_q[j][p])
               plane[c] = plane[c] + extend(matrix_i[(j*W+c)*WSM +: WSM], mat_signed_q);
         end
         if (vec_signed_q && last_plane)
            acc_next[c] = acc[c] - (plane[c] << p);
         else
            acc_next[c] = acc[c] + (plane[c] << p);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         p            <= '0;
         nbits_q      <= '0;
         vec_signed_q <= 1'b0;
         mat_signed_q <= 1'b0;
         for (int j = 0; j < H; j++) vec_q[j] <= '0;
         for (int c = 0; c < W; c++) acc[c] <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            p            <= '0;
            nbits_q      <= nbits_eff;
            vec_signed_q <= vec_signed_i;
            mat_signed_q <= mat_signed_i;
            for (int j = 0; j < H; j++) vec_q[j] <= vector_i[j*VEC_BITS +: VEC_BITS];
            for (int c = 0; c < W; c++) acc[c] <= '0;
         end else if (state == COMPUTE) begin
            p <= p + P_W'(1);
            for (int c = 0; c < W; c++) acc[c] <= acc_next[c];
         end
      end
   end

   for (genvar c = 0; c < W; c++) begin : g_result
      assign result_o[c*WORD_SIZE +: WORD_SIZE] = acc[c];
   end

endmodule

// File: tb/tb_dot_product_bitserial.sv
// Bench for dot_product_bitserial (H=4, W=2): table of directed vectors, random requests
// against an integer reference model, backpressure and mid-compute reset sequences.
module tb_dot_product_bitserial;

   localparam int H  = 4;
   localparam int W  = 2;
   localparam int WS = 16;

   typedef struct packed {
      logic [31:0] vec;
      logic [63:0] mat;
      logic [3:0]  nbits;
      logic        vs;
      logic        ms;
      logic [31:0] exp;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] vector_i = '0;
   logic [3:0]  nbits_i = '0;
   logic        vec_signed_i = 1'b0;
   logic        mat_signed_i = 1'b0;
   logic [63:0] matrix_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] result_o;
   logic        busy_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];
   vec_t        tbl[10];

   dot_product_bitserial #(
      .RRAM_DOTP_HEIGHT(H), .RRAM_DOTP_WIDTH(W), .WORD_SIZE(WS),
      .WORD_SIZE_MATRIX(8), .VEC_BITS(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .vector_i(vector_i), .nbits_i(nbits_i), .vec_signed_i(vec_signed_i),
      .mat_signed_i(mat_signed_i), .matrix_i(matrix_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .result_o(result_o), .busy_o(busy_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] v4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [63:0] mk_mat(input logic [31:0] col0, input logic [31:0] col1);
      logic [63:0] m;
      m = '0;
      for (int j = 0; j < 4; j++) begin
         m[(j*2)*8 +: 8]   = col0[j*8 +: 8];
         m[(j*2+1)*8 +: 8] = col1[j*8 +: 8];
      end
      return m;
   endfunction

   function automatic logic [31:0] model(input vec_t r);
      int n, v, m, s;
      logic [31:0] res;
      res = '0;
      n = (r.nbits == 0 || r.nbits > 8) ? 8 : int'(r.nbits);
      for (int c = 0; c < 2; c++) begin
         s = 0;
         for (int j = 0; j < 4; j++) begin
            v = int'(r.vec[j*8 +: 8]) & ((1 << n) - 1);
            if (r.vs && v >= (1 << (n - 1))) v -= (1 << n);
            m = int'(r.mat[(j*2+c)*8 +: 8]);
            if (r.ms && m >= 128) m -= 256;
            s += v * m;
         end
         res[c*16 +: 16] = s[15:0];
      end
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver + scoreboard for one request; hold = cycles of result backpressure
   task automatic run_req(input vec_t r, input int hold, input string tag);
      int k;
      int t_acc;
      int lat;
      logic [31:0] exp_res;
      k = 0;
      while (!in_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      check({tag, " in_ready"}, 32'(in_ready_o), 32'd1);
      vector_i = r.vec; matrix_i = r.mat; nbits_i = r.nbits;
      vec_signed_i = r.vs; mat_signed_i = r.ms;
      in_valid_i = 1'b1;
      out_ready_i = (hold == 0);
      @(negedge clk_i);
      t_acc = cyc;
      in_valid_i = 1'b0;
      exp_q.push_back(r.exp);
      lat = (r.nbits == 0 || r.nbits > 8) ? 8 : int'(r.nbits);
      vector_i = $urandom;
      nbits_i = 4'($urandom_range(0, 15));
      vec_signed_i = ~r.vs;
      mat_signed_i = ~r.ms;
      check({tag, " busy"}, 32'(busy_o), 32'd1);
      k = 0;
      while (!out_valid_o && k < 40) begin
         @(negedge clk_i);
         k++;
      end
      check({tag, " out_valid"}, 32'(out_valid_o), 32'd1);
      check({tag, " latency"}, 32'(cyc - t_acc), 32'(lat));
      exp_res = exp_q.pop_front();
      check({tag, " result"}, result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         in_valid_i = 1'b1;
         vector_i = $urandom;
         @(negedge clk_i);
         check({tag, " hold valid"}, 32'(out_valid_o), 32'd1);
         check({tag, " hold ready"}, 32'(in_ready_o), 32'd0);
         check({tag, " hold result"}, result_o, exp_res);
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      check({tag, " released valid"}, 32'(out_valid_o), 32'd0);
      check({tag, " released ready"}, 32'(in_ready_o), 32'd1);
      check({tag, " released busy"}, 32'(busy_o), 32'd0);
      check({tag, " idle result"}, result_o, exp_res);
   endtask

   initial begin
      vec_t r;
      tbl[0] = '{vec: v4(3, 1, 0, 2), mat: mk_mat(v4(1, 2, 3, 4), v4(5, 6, 7, 8)),
                 nbits: 4'd2, vs: 1'b0, ms: 1'b0, exp: {16'd37, 16'd13}};
      tbl[1] = '{vec: v4(8'hFF, 2, 0, 0), mat: mk_mat(v4(10, 1, 0, 0), v4(1, 1, 1, 1)),
                 nbits: 4'd8, vs: 1'b1, ms: 1'b0, exp: {16'h0001, 16'hFFF8}};
      tbl[2] = '{vec: v4(5, 0, 0, 0), mat: mk_mat(v4(8'hFD, 0, 0, 0), v4(2, 0, 0, 0)),
                 nbits: 4'd3, vs: 1'b0, ms: 1'b1, exp: {16'h000A, 16'hFFF1}};
      tbl[3] = '{vec: v4(1, 0, 1, 0), mat: mk_mat(v4(3, 9, 4, 9), v4(1, 1, 1, 1)),
                 nbits: 4'd1, vs: 1'b1, ms: 1'b0, exp: {16'hFFFE, 16'hFFF9}};
      tbl[4] = '{vec: v4(8'hFF, 8'hFF, 8'hFF, 8'hFF),
                 mat: mk_mat(v4(8'hFF, 8'hFF, 8'hFF, 8'hFF), v4(8'hFF, 8'hFF, 8'hFF, 8'hFF)),
                 nbits: 4'd8, vs: 1'b0, ms: 1'b0, exp: {16'hF804, 16'hF804}};
      tbl[5] = '{vec: v4(200, 0, 0, 0), mat: mk_mat(v4(2, 0, 0, 0), v4(1, 0, 0, 0)),
                 nbits: 4'd0, vs: 1'b0, ms: 1'b0, exp: {16'h00C8, 16'h0190}};
      tbl[6] = '{vec: v4(1, 1, 1, 1), mat: mk_mat(v4(1, 2, 3, 4), v4(8'h80, 8'h80, 8'h80, 8'h80)),
                 nbits: 4'd15, vs: 1'b0, ms: 1'b0, exp: {16'h0200, 16'h000A}};
      tbl[7] = '{vec: v4(8'hF5, 0, 0, 0), mat: mk_mat(v4(3, 0, 0, 0), v4(1, 0, 0, 0)),
                 nbits: 4'd4, vs: 1'b0, ms: 1'b0, exp: {16'h0005, 16'h000F}};
      tbl[8] = '{vec: v4(8'hFE, 3, 0, 0), mat: mk_mat(v4(8'hFF, 8'hFE, 0, 0), v4(5, 1, 0, 0)),
                 nbits: 4'd8, vs: 1'b1, ms: 1'b1, exp: {16'hFFF9, 16'hFFFC}};
      tbl[9] = '{vec: v4(6, 0, 0, 0), mat: mk_mat(v4(7, 0, 0, 0), v4(1, 0, 0, 0)),
                 nbits: 4'd3, vs: 1'b1, ms: 1'b0, exp: {16'hFFFE, 16'hFFF2}};

      repeat (2) @(negedge clk_i);
      check("reset in_ready", 32'(in_ready_o), 32'd1);
      check("reset out_valid", 32'(out_valid_o), 32'd0);
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset result", result_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 10; i++) run_req(tbl[i], 0, $sformatf("tbl%0d", i));

      run_req(tbl[0], 5, "backpressure");

      vector_i = tbl[4].vec; matrix_i = tbl[4].mat; nbits_i = 4'd8;
      vec_signed_i = 1'b0; mat_signed_i = 1'b0;
      in_valid_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("pre-reset busy", 32'(busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("mid reset in_ready", 32'(in_ready_o), 32'd1);
      check("mid reset out_valid", 32'(out_valid_o), 32'd0);
      check("mid reset busy", 32'(busy_o), 32'd0);
      check("mid reset result", result_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_req(tbl[4], 0, "after reset wrap");
      run_req(tbl[0], 1, "after reset t1");

      for (int i = 0; i < 12; i++) begin
         r.vec = $urandom;
         r.mat = {$urandom, $urandom};
         r.nbits = 4'($urandom_range(0, 15));
         r.vs = 1'($urandom_range(0, 1));
         r.ms = 1'($urandom_range(0, 1));
         r.exp = model(r);
         run_req(r, $urandom_range(0, 2), $sformatf("rand%0d", i));
      end

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
